// File: rtl/alu_slice_sequencer_pkg.sv
// Shared types and constants for the multi-slice ALU operand sequencer.
package alu_seq_pkg;

  localparam int unsigned SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // ALU select codes; XOR and PASS_A are only meaningful with mode = 1
  localparam logic [3:0] SEL_ADD    = 4'b1001;
  localparam logic [3:0] SEL_SUB    = 4'b0110;
  localparam logic [3:0] SEL_XOR    = 4'b0110;
  localparam logic [3:0] SEL_PASS_A = 4'b1111;

  // Operation control latched at accept and replayed on every slice
  typedef struct packed {
    logic [3:0] select;
    logic       mode;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_slice_sequencer_if.sv
// Request/response channels between the control path and the sequencer.
interface alu_slice_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int unsigned SLICES = 4
);
  localparam int unsigned W = SLICE_W * SLICES;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [3:0]   req_select;
  logic         req_mode;
  logic         req_carry;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic         rsp_zero;

  // Sequencer side
  modport slave (
    input  req_valid, req_a, req_b, req_select, req_mode, req_carry, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

  // Requesting/consuming side
  modport master (
    output req_valid, req_a, req_b, req_select, req_mode, req_carry, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

endinterface

// File: rtl/alu_slice_sequencer.sv
// Issues one wide operation to a 16-bit combinational ALU, one slice per
// cycle LSB first, chaining carry/borrow, and returns the assembled result.
module alu_slice_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SLICES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_slice_sequencer_if.slave bus,
  output logic [SLICE_W-1:0]   alu_a,
  output logic [SLICE_W-1:0]   alu_b,
  output logic [3:0]           alu_select,
  output logic                 alu_mode,
  output logic                 alu_carry_in,
  input  logic [SLICE_W-1:0]   alu_result,
  input  logic                 alu_carry_out
);

  localparam int unsigned W     = SLICE_W * SLICES;
  localparam int unsigned IDX_W = $clog2(SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  state_e           state;
  state_e           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     result;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  alu_ctrl_t        ctrl_q;
  logic             accept_c;

  assign accept_c = bus.req_valid && bus.req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, slice index, running carry and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            a_q           <= bus.req_a;
            b_q           <= bus.req_b;
            ctrl_q.select <= bus.req_select;
            ctrl_q.mode   <= bus.req_mode;
            // logic mode never consumes a carry
            carry         <= bus.req_carry & ~bus.req_mode;
            result        <= '0;
            idx           <= '0;
          end
        end
        RUN: begin
          result[SLICE_W*idx +: SLICE_W] <= alu_result;
          carry <= ctrl_q.mode ? 1'b0 : alu_carry_out;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode: handshakes from state, ALU drive only while running
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_result = result;
    bus.rsp_carry  = carry;
    bus.rsp_zero   = (result == '0);
    alu_a          = '0;
    alu_b          = '0;
    alu_select     = '0;
    alu_mode       = 1'b0;
    alu_carry_in   = 1'b0;
    case (state)
      IDLE: bus.req_ready = ~rst;
      RUN: begin
        alu_a        = a_q[SLICE_W*idx +: SLICE_W];
        alu_b        = b_q[SLICE_W*idx +: SLICE_W];
        alu_select   = ctrl_q.select;
        alu_mode     = ctrl_q.mode;
        alu_carry_in = carry;
      end
      DONE: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer with a behavioural 16-bit ALU peer and a
// whole-width reference model.
module tb_alu_slice_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned SLICES = 4;
  localparam int unsigned W      = SLICE_W * SLICES;
  localparam int unsigned W1     = W + 1;

  logic clk = 1'b0;
  logic rst;

  logic [SLICE_W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]         alu_select;
  logic               alu_mode, alu_carry_in, alu_carry_out;

  int total = 0;
  int bad   = 0;

  alu_slice_sequencer_if #(.SLICES(SLICES)) bus ();

  alu_slice_sequencer #(.SLICES(SLICES)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_select    (alu_select),
    .alu_mode      (alu_mode),
    .alu_carry_in  (alu_carry_in),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out)
  );

  always #5 clk = ~clk;

  // 16-bit ALU peer (subset of codes used here)
  always_comb begin
    logic [SLICE_W:0] t;
    t = '0;
    if (alu_mode) begin
      if (alu_select == SEL_PASS_A) t = {1'b0, alu_a};
      else if (alu_select == SEL_XOR) t = {1'b0, alu_a ^ alu_b};
      else t = {1'b0, alu_a & alu_b};
    end else if (alu_select == SEL_SUB) begin
      t = {1'b0, alu_a} - {1'b0, alu_b} - 17'(alu_carry_in);
    end else begin
      t = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_carry_in);
    end
    alu_result    = t[SLICE_W-1:0];
    alu_carry_out = alu_mode ? 1'b0 : t[SLICE_W];
  end

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-width reference: plain wide arithmetic, no slicing
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [3:0] sel, input logic mode, input logic cin,
                                output logic [W-1:0] r, output logic c);
    logic [W:0] t;
    if (mode) begin
      r = (sel == SEL_PASS_A) ? a : (a ^ b);
      c = 1'b0;
    end else if (sel == SEL_ADD) begin
      t = {1'b0, a} + {1'b0, b} + W1'(cin);
      r = t[W-1:0];
      c = t[W];
    end else begin
      r = a - b - W'(cin);
      c = ({1'b0, a} < ({1'b0, b} + W1'(cin)));
    end
  endfunction

  // Issue one operation from a negedge, check latency/response, then
  // hold rsp_ready low for 'hold' cycles before completing the handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] sel, input logic mode, input logic cin,
                        input int hold, output logic [SLICES-1:0] cin_seen);
    logic [W-1:0] er, held_r;
    logic         ec, held_c, held_z;
    bit           accepted;
    int           cyc;
    model(a, b, sel, mode, cin, er, ec);
    cin_seen = '0;
    bus.req_valid  = 1'b1;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_select = sel;
    bus.req_mode   = mode;
    bus.req_carry  = cin;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        @(posedge clk);
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", W1'(accepted), W1'(1));
    if (!accepted) begin
      bus.req_valid = 1'b0;
      return;
    end
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      cyc = i;
      if (i == 1) begin
        chk("alu_select", W1'(alu_select), W1'(sel));
        chk("alu_mode", W1'(alu_mode), W1'(mode));
        chk("alu_a_slice0", W1'(alu_a), W1'(a[SLICE_W-1:0]));
        // requests presented while busy must be ignored
        bus.req_a = ~a;
        bus.req_b = ~b;
      end
      if (i <= SLICES) cin_seen[i-1] = alu_carry_in;
      if (bus.rsp_valid) break;
    end
    chk("latency", W1'(cyc), W1'(SLICES + 1));
    chk("rsp_result", W1'(bus.rsp_result), W1'(er));
    chk("rsp_carry", W1'(bus.rsp_carry), W1'(ec));
    chk("rsp_zero", W1'(bus.rsp_zero), W1'(er == '0));
    chk("alu_a_idle_done", W1'({alu_a, alu_b, alu_select, alu_mode, alu_carry_in}), W1'(0));
    held_r = bus.rsp_result;
    held_c = bus.rsp_carry;
    held_z = bus.rsp_zero;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", W1'(bus.rsp_valid), W1'(1));
      chk("hold_req_ready", W1'(bus.req_ready), W1'(0));
      chk("hold_result", W1'(bus.rsp_result), W1'(held_r));
      chk("hold_flags", W1'({bus.rsp_carry, bus.rsp_zero}), W1'({held_c, held_z}));
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_hs_valid", W1'(bus.rsp_valid), W1'(0));
    chk("post_hs_req_ready", W1'(bus.req_ready), W1'(1));
  endtask

  initial begin
    logic [SLICES-1:0] cs;
    logic [3:0]        rsel;
    logic              rmode;
    int                pick;
    bit                seen;

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_select = '0;
    bus.req_mode   = 1'b0;
    bus.req_carry  = 1'b0;
    bus.rsp_ready  = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", W1'(bus.req_ready), W1'(0));
    chk("rst_rsp_valid", W1'(bus.rsp_valid), W1'(0));
    chk("rst_rsp_carry", W1'(bus.rsp_carry), W1'(0));
    chk("rst_rsp_zero", W1'(bus.rsp_zero), W1'(1));
    chk("rst_alu_drive", W1'({alu_a, alu_b, alu_select, alu_mode, alu_carry_in}), W1'(0));
    rst = 1'b0;
    #1;
    chk("rel_req_ready", W1'(bus.req_ready), W1'(1));
    @(negedge clk);

    // add with inter-slice carry
    run_op(64'h0000_0000_0000_FFFF, 64'h1, SEL_ADD, 1'b0, 1'b0, 0, cs);
    chk("add_cin_slice1", W1'(cs[1]), W1'(1));
    chk("add_cin_slice0", W1'(cs[0]), W1'(0));

    // add wrap
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, SEL_ADD, 1'b0, 1'b0, 0, cs);
    chk("wrap_cin_all", W1'(cs), W1'(4'b1110));

    // subtract with borrow
    run_op(64'h0000_0000_0001_0000, 64'h1, SEL_SUB, 1'b0, 1'b0, 0, cs);
    chk("sub_cin_slice1", W1'(cs[1]), W1'(1));

    // logic XOR with req_carry set: carry must never reach the ALU
    run_op(64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, SEL_XOR, 1'b1, 1'b1, 0, cs);
    chk("xor_cin_none", W1'(cs), W1'(0));

    // backpressure
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, SEL_ADD, 1'b0, 1'b1, 6, cs);

    // reset during slice 2
    bus.req_valid  = 1'b1;
    bus.req_a      = 64'h1111_2222_3333_4444;
    bus.req_b      = 64'h5;
    bus.req_select = SEL_ADD;
    bus.req_mode   = 1'b0;
    bus.req_carry  = 1'b0;
    chk("abort_ready", W1'(bus.req_ready), W1'(1));
    @(posedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_alu_drive", W1'({alu_a, alu_b, alu_select, alu_mode, alu_carry_in}), W1'(0));
    chk("abort_rsp_valid", W1'(bus.rsp_valid), W1'(0));
    chk("abort_req_ready_in_rst", W1'(bus.req_ready), W1'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_req_ready_after", W1'(bus.req_ready), W1'(1));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("abort_no_rsp", W1'(seen), W1'(0));
    run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, SEL_ADD, 1'b0, 1'b0, 1, cs);

    // randomized operations against the wide model
    for (int n = 0; n < 16; n++) begin
      pick = int'($urandom_range(0, 3));
      case (pick)
        0:       begin rsel = SEL_ADD;    rmode = 1'b0; end
        1:       begin rsel = SEL_SUB;    rmode = 1'b0; end
        2:       begin rsel = SEL_XOR;    rmode = 1'b1; end
        default: begin rsel = SEL_PASS_A; rmode = 1'b1; end
      endcase
      run_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, rsel, rmode,
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), cs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_slice_sequencer.md
# alu_slice_sequencer

Multi-slice operand sequencer that acts as the initiator for the 16-bit ALU datapath. It accepts one wide (16×SLICES-bit) operation over a valid/ready request channel. It issues it to the ALU one 16-bit slice per cycle, least-significant first, chaining carry/borrow between slices. It then returns the assembled result, final carry and zero flag on a valid/ready response channel. It sits between the instruction/control path and the combinational ALU, and is the only driver of the ALU's operand and control inputs.

## Interface
- SLICES, 4, number of 16-bit slices; operand width W = 16*SLICES (min 2).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE and rst low.
- req_a, req_b  in  W  operands.
- req_select  in  4  ALU select code, passed unchanged to every slice.
- req_mode  in  1  1 = logic, 0 = arithmetic.
- req_carry  in  1  carry/borrow into slice 0 (arithmetic only).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  W  assembled result.
- rsp_carry  out  1  carry_out of last slice; 0 in logic mode.
- rsp_zero  out  1  rsp_result == 0.
- alu_a, alu_b  out  16  current slice of latched operands.
- alu_select  out  4  latched select.
- alu_mode  out  1  latched mode.
- alu_carry_in  out  1  running carry.
- alu_result  in  16  ALU combinational result for current slice.
- alu_carry_out  in  1  ALU carry/borrow out for current slice.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch a, b, select, mode, and carry (forced 0 if req_mode=1). Clear the result register, set idx=0, go to RUN.
- RUN: drive alu_a/alu_b with slice idx of latched operands, alu_carry_in = running carry. At each edge, write alu_result into result[16*idx +: 16]. Set carry <= alu_carry_out if arithmetic, else 0. If idx==SLICES-1 go to DONE, else idx++.
- DONE: rsp_valid=1. rsp_result, rsp_carry and rsp_zero are held stable. On rsp_ready go to IDLE.
- Carry semantics are the ALU's: for add codes carry_out is the carry; for subtract codes (e.g. 4'b0110, A-B-cin) carry_out is the borrow. It is chained unchanged either way.
- Outside RUN, alu_a, alu_b, alu_select, alu_mode and alu_carry_in are driven 0.
- req_* inputs are ignored outside IDLE; no queueing.
- Reset: state IDLE, idx 0, carry 0, result 0, rsp_valid 0, rsp_carry 0. rsp_zero reflects 0, i.e. 1, but is meaningful only with rsp_valid. req_ready 0 while rst high. All ALU drive outputs 0.
- Reset mid-RUN or mid-DONE aborts: no response is produced and partial results are discarded.

## Timing
- Accept at edge E0 → RUN during cycles E0..E_SLICES. Slice k is captured at edge E(k+1).
- rsp_valid first high in the cycle after E_SLICES, i.e. SLICES+1 cycles after accept.
- Earliest next accept: the cycle after the response handshake. Minimum request period is SLICES+2 cycles.
- ALU path is combinational within one cycle: alu_* outputs → alu_result/alu_carry_out → result register.
- rsp_ready asserted before rsp_valid has no effect.

## Structure
- Package alu_seq_pkg holds:
  - SLICE_W=16;
  - state enum {IDLE, RUN, DONE};
  - select constants SEL_ADD=4'b1001 (A+B+cin), SEL_SUB=4'b0110 (A-B-cin), SEL_XOR=4'b0110 with mode 1, SEL_PASS_A=4'b1111 with mode 1.
- Single module, no sub-module. The ALU is an external peer, instantiated alongside it at the next level up and in the bench.
- idx counter width is $clog2(SLICES).

## Test plan
All scenarios use SLICES=4, with the real ALU connected.
- Add with inter-slice carry: a=0x0000_0000_0000_FFFF, b=0x1, sel 1001, mode 0, cin 0 → result 0x0000_0000_0001_0000, carry 0, zero 0. alu_carry_in=1 on slice 1. rsp_valid exactly 5 cycles after accept.
- Add wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1 → result 0, carry 1, zero 1.
- Subtract with borrow: a=0x0000_0000_0001_0000, b=0x1, sel 0110, mode 0, cin 0 → result 0x0000_0000_0000_FFFF, carry 0. alu_carry_in=1 on slice 1.
- Logic XOR: a=0xAAAA_AAAA_AAAA_AAAA, b=all-ones, sel 0110, mode 1, req_carry 1 → result 0x5555_5555_5555_5555, carry 0. alu_carry_in=0 on every slice.
- Backpressure: hold rsp_ready low 6 cycles after rsp_valid → rsp_* stable and req_ready 0 throughout. A new request is accepted the cycle after rsp_ready rises.
- Reset during slice 2 → rsp_valid never rises, all alu_* outputs 0. req_ready=1 in the first cycle after rst falls, and the next request completes normally.
